// File: rtl/trap_ctrl_if.sv
// Bundle between trap_ctrl and the pipeline stages, the CSR file and pipeline control.
// The master modport is the pipeline/CSR side. The slave modport is the trap controller.
// This file holds connectivity only: no logic and no storage.
interface trap_ctrl_if #(
    parameter int XLEN      = 64,
    parameter int N_EXT_IRQ = 4,
    parameter int CAUSE_W   = 4
);
    logic                 exc_vld_if,   exc_vld_id,   exc_vld_ex;
    logic [CAUSE_W-1:0]   exc_cause_if, exc_cause_id, exc_cause_ex;
    logic [XLEN-1:0]      exc_pc_if,    exc_pc_id,    exc_pc_ex;
    logic [XLEN-1:0]      exc_tval_if,  exc_tval_id,  exc_tval_ex;
    logic                 mret_i;
    logic                 tmr_irq_i;
    logic                 sw_irq_i;
    logic [N_EXT_IRQ-1:0] ext_irq_i;
    logic [XLEN-1:0]      int_pc_i;
    logic [XLEN-1:0]      csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i;
    logic                 trap_req_o;
    logic [XLEN-1:0]      trap_addr_o;
    logic                 hold_o;
    logic [N_EXT_IRQ-1:0] ext_claim_o;
    logic                 csr_we_o;
    logic [11:0]          csr_addr_o;
    logic [XLEN-1:0]      csr_data_o;

    modport master (
        output exc_vld_if, exc_vld_id, exc_vld_ex,
        output exc_cause_if, exc_cause_id, exc_cause_ex,
        output exc_pc_if, exc_pc_id, exc_pc_ex,
        output exc_tval_if, exc_tval_id, exc_tval_ex,
        output mret_i, tmr_irq_i, sw_irq_i, ext_irq_i, int_pc_i,
        output csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
        input  trap_req_o, trap_addr_o, hold_o, ext_claim_o,
        input  csr_we_o, csr_addr_o, csr_data_o
    );

    modport slave (
        input  exc_vld_if, exc_vld_id, exc_vld_ex,
        input  exc_cause_if, exc_cause_id, exc_cause_ex,
        input  exc_pc_if, exc_pc_id, exc_pc_ex,
        input  exc_tval_if, exc_tval_id, exc_tval_ex,
        input  mret_i, tmr_irq_i, sw_irq_i, ext_irq_i, int_pc_i,
        input  csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
        output trap_req_o, trap_addr_o, hold_o, ext_claim_o,
        output csr_we_o, csr_addr_o, csr_data_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller. It prioritises sync exceptions, MRET and interrupts, then sequences the CSR writes.
// The redirect (trap_req_o/trap_addr_o) is registered and appears 1 cycle after the event. CSR writes follow, one per cycle.
// There is no backpressure input. hold_o stalls the pipeline while busy, and events seen outside IDLE are ignored.
// Define TRAP_VECTORED_EN to send interrupts to base + 4*code when mtvec[1:0] == 2'b01.
module trap_ctrl #(
    parameter int XLEN      = 64,
    parameter int N_EXT_IRQ = 4,
    parameter int CAUSE_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    trap_ctrl_if.slave  bus
);
    // One-hot sequencer states
    localparam logic [5:0] S_IDLE    = 6'b000001;
    localparam logic [5:0] S_MEPC    = 6'b000010;
    localparam logic [5:0] S_MCAUSE  = 6'b000100;
    localparam logic [5:0] S_MTVAL   = 6'b001000;
    localparam logic [5:0] S_MSTATUS = 6'b010000;
    localparam logic [5:0] S_MRET    = 6'b100000;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    logic [5:0]           state;
    logic [XLEN-1:0]      cap_cause, cap_tval;
    logic                 trap_req_q, csr_we_q;
    logic [XLEN-1:0]      trap_addr_q, csr_data_q;
    logic [11:0]          csr_addr_q;
    logic [N_EXT_IRQ-1:0] ext_claim_q;

    logic                 sync_vld, mei, msi, mti, irq_vld, ext_found;
    logic                 ev_trap, ev_mret, ev_int;
    logic [CAUSE_W-1:0]   sync_code;
    logic [3:0]           irq_code;
    logic [XLEN-1:0]      sync_pc, sync_tval, ev_pc, ev_cause, ev_tval;
    logic [XLEN-1:0]      base, trap_tgt, trap_mstatus, mret_mstatus;
    logic [N_EXT_IRQ-1:0] ext_sel;
    logic                 unused_bits;

    // Pick the winning event: sync exception (EX > ID > IF), then MRET, then enabled interrupt (MEI > MSI > MTI)
    always_comb begin
        sync_vld  = bus.exc_vld_ex | bus.exc_vld_id | bus.exc_vld_if;
        sync_code = bus.exc_cause_if;
        sync_pc   = bus.exc_pc_if;
        sync_tval = bus.exc_tval_if;
        if (bus.exc_vld_ex) begin
            sync_code = bus.exc_cause_ex;
            sync_pc   = bus.exc_pc_ex;
            sync_tval = bus.exc_tval_ex;
        end else if (bus.exc_vld_id) begin
            sync_code = bus.exc_cause_id;
            sync_pc   = bus.exc_pc_id;
            sync_tval = bus.exc_tval_id;
        end

        ext_sel   = '0;
        ext_found = 1'b0;
        for (int i = 0; i < N_EXT_IRQ; i++) begin
            if (bus.ext_irq_i[i] && !ext_found) begin
                ext_sel[i] = 1'b1;
                ext_found  = 1'b1;
            end
        end

        mei      = bus.csr_mie_i[11] & (|bus.ext_irq_i);
        msi      = bus.csr_mie_i[3]  & bus.sw_irq_i;
        mti      = bus.csr_mie_i[7]  & bus.tmr_irq_i;
        irq_vld  = bus.csr_mstatus_i[3] & (mei | msi | mti);
        irq_code = mei ? 4'd11 : (msi ? 4'd3 : 4'd7);

        ev_int   = !sync_vld && !bus.mret_i && irq_vld;
        ev_trap  = sync_vld || ev_int;
        ev_mret  = !sync_vld && bus.mret_i;

        ev_cause = ev_int ? {1'b1, (XLEN-1)'(irq_code)} : {1'b0, (XLEN-1)'(sync_code)};
        ev_pc    = ev_int ? bus.int_pc_i : sync_pc;
        ev_tval  = ev_int ? '0 : sync_tval;

        base     = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};
        trap_tgt = base;
`ifdef TRAP_VECTORED_EN
        if (ev_int && bus.csr_mtvec_i[1:0] == 2'b01)
            trap_tgt = base + (XLEN'(irq_code) << 2);
`endif

        trap_mstatus        = bus.csr_mstatus_i;
        trap_mstatus[7]     = bus.csr_mstatus_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;

        mret_mstatus        = bus.csr_mstatus_i;
        mret_mstatus[3]     = bus.csr_mstatus_i[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b11;
    end

    // Only some mie bits and the mtvec mode bits matter here
    assign unused_bits = ^{bus.csr_mie_i, bus.csr_mtvec_i[1:0]};

    // Sequencer: the redirect and the first write are loaded on the event edge, then one CSR write per state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cap_cause   <= '0;
            cap_tval    <= '0;
            trap_req_q  <= 1'b0;
            trap_addr_q <= '0;
            ext_claim_q <= '0;
            csr_we_q    <= 1'b0;
            csr_addr_q  <= '0;
            csr_data_q  <= '0;
        end else begin
            trap_req_q  <= 1'b0;
            ext_claim_q <= '0;
            case (state)
                S_IDLE: begin
                    csr_we_q <= 1'b0;
                    if (ev_trap) begin
                        state       <= S_MEPC;
                        cap_cause   <= ev_cause;
                        cap_tval    <= ev_tval;
                        trap_req_q  <= 1'b1;
                        trap_addr_q <= trap_tgt;
                        ext_claim_q <= (ev_int && mei) ? ext_sel : '0;
                        csr_we_q    <= 1'b1;
                        csr_addr_q  <= A_MEPC;
                        csr_data_q  <= ev_pc;
                    end else if (ev_mret) begin
                        state       <= S_MRET;
                        trap_req_q  <= 1'b1;
                        trap_addr_q <= bus.csr_mepc_i;
                        csr_we_q    <= 1'b1;
                        csr_addr_q  <= A_MSTATUS;
                        csr_data_q  <= mret_mstatus;
                    end
                end
                S_MEPC: begin
                    state      <= S_MCAUSE;
                    csr_addr_q <= A_MCAUSE;
                    csr_data_q <= cap_cause;
                end
                S_MCAUSE: begin
                    state      <= S_MTVAL;
                    csr_addr_q <= A_MTVAL;
                    csr_data_q <= cap_tval;
                end
                S_MTVAL: begin
                    state      <= S_MSTATUS;
                    csr_addr_q <= A_MSTATUS;
                    csr_data_q <= trap_mstatus;
                end
                default: begin
                    state    <= S_IDLE;
                    csr_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trap_req_o  = trap_req_q;
    assign bus.trap_addr_o = trap_addr_q;
    assign bus.ext_claim_o = ext_claim_q;
    assign bus.csr_we_o    = csr_we_q;
    assign bus.csr_addr_o  = csr_addr_q;
    assign bus.csr_data_o  = csr_data_q;
    assign bus.hold_o      = (state != S_IDLE);
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with hand-computed expected values.
// Inputs change 1 ns after the rising edge, and outputs are checked at that same point.
// The vectored-target step follows the TRAP_VECTORED_EN build.
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    trap_ctrl_if #(.XLEN(64), .N_EXT_IRQ(4), .CAUSE_W(4)) bus ();

    trap_ctrl #(.XLEN(64), .N_EXT_IRQ(4), .CAUSE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [11:0] a, input logic [63:0] d);
        chk({tag, "_we"},   64'(bus.csr_we_o),   64'd1);
        chk({tag, "_addr"}, 64'(bus.csr_addr_o), 64'(a));
        chk({tag, "_data"}, bus.csr_data_o,      d);
    endtask

    task automatic clr_exc();
        bus.exc_vld_if = 1'b0; bus.exc_vld_id = 1'b0; bus.exc_vld_ex = 1'b0;
        bus.mret_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_exc();
        bus.exc_cause_if = '0; bus.exc_cause_id = '0; bus.exc_cause_ex = '0;
        bus.exc_pc_if = '0;    bus.exc_pc_id = '0;    bus.exc_pc_ex = '0;
        bus.exc_tval_if = '0;  bus.exc_tval_id = '0;  bus.exc_tval_ex = '0;
        bus.tmr_irq_i = 1'b0; bus.sw_irq_i = 1'b0; bus.ext_irq_i = '0;
        bus.int_pc_i = 64'h8000_0200;
        bus.csr_mstatus_i = 64'h8;
        bus.csr_mie_i = '0;
        bus.csr_mtvec_i = 64'h8000_0100;
        bus.csr_mepc_i = '0;

        // Reset state
        #12;
        chk("rst_trap_req", 64'(bus.trap_req_o), 64'd0);
        chk("rst_hold",     64'(bus.hold_o),     64'd0);
        chk("rst_we",       64'(bus.csr_we_o),   64'd0);
        chk("rst_data",     bus.csr_data_o,      64'd0);
        chk("rst_claim",    64'(bus.ext_claim_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ID exception, cause 2
        bus.exc_vld_id = 1'b1; bus.exc_cause_id = 4'd2;
        bus.exc_pc_id = 64'h8000_0010; bus.exc_tval_id = 64'h13;
        tick();
        clr_exc();
        chk("id_trap_req", 64'(bus.trap_req_o), 64'd1);
        chk("id_trap_addr", bus.trap_addr_o, 64'h8000_0100);
        chk("id_hold1", 64'(bus.hold_o), 64'd1);
        chk_wr("id_mepc", 12'h341, 64'h8000_0010);
        // An EX exception raised while busy must not disturb the sequence
        bus.exc_vld_ex = 1'b1; bus.exc_cause_ex = 4'd7; bus.exc_pc_ex = 64'hdead;
        tick();
        chk("id_req_pulse", 64'(bus.trap_req_o), 64'd0);
        chk("id_hold2", 64'(bus.hold_o), 64'd1);
        chk_wr("id_mcause", 12'h342, 64'd2);
        tick();
        chk_wr("id_mtval", 12'h343, 64'h13);
        chk("id_hold3", 64'(bus.hold_o), 64'd1);
        tick();
        clr_exc();
        chk_wr("id_mstatus", 12'h300, 64'h1880);
        chk("id_hold4", 64'(bus.hold_o), 64'd1);
        tick();
        chk("id_hold_end", 64'(bus.hold_o), 64'd0);
        chk("id_we_end", 64'(bus.csr_we_o), 64'd0);
        chk("id_req_end", 64'(bus.trap_req_o), 64'd0);

        // IF and EX in the same cycle: EX wins
        bus.exc_vld_if = 1'b1; bus.exc_cause_if = 4'd1; bus.exc_pc_if = 64'h1000;
        bus.exc_vld_ex = 1'b1; bus.exc_cause_ex = 4'd5; bus.exc_pc_ex = 64'h2000;
        bus.exc_tval_ex = 64'h55;
        tick();
        clr_exc();
        chk_wr("ex_mepc", 12'h341, 64'h2000);
        tick();
        chk_wr("ex_mcause", 12'h342, 64'd5);
        tick();
        chk_wr("ex_mtval", 12'h343, 64'h55);
        repeat (2) tick();
        chk("ex_idle", 64'(bus.hold_o), 64'd0);

        // MEI beats MTI. The lowest asserted line (bit 1) is claimed.
        bus.csr_mie_i = 64'h880; bus.tmr_irq_i = 1'b1; bus.ext_irq_i = 4'b0110;
        tick();
        bus.tmr_irq_i = 1'b0; bus.ext_irq_i = '0;
        chk("mei_trap_req", 64'(bus.trap_req_o), 64'd1);
        chk("mei_addr", bus.trap_addr_o, 64'h8000_0100);
        chk("mei_claim", 64'(bus.ext_claim_o), 64'b0010);
        chk_wr("mei_mepc", 12'h341, 64'h8000_0200);
        tick();
        chk("mei_claim_pulse", 64'(bus.ext_claim_o), 64'd0);
        chk_wr("mei_mcause", 12'h342, 64'h8000_0000_0000_000B);
        tick();
        chk_wr("mei_mtval", 12'h343, 64'd0);
        tick();
        chk_wr("mei_mstatus", 12'h300, 64'h1880);
        tick();
        chk("mei_idle", 64'(bus.hold_o), 64'd0);

        // MRET
        bus.csr_mstatus_i = 64'h80; bus.csr_mepc_i = 64'h8000_0040; bus.mret_i = 1'b1;
        tick();
        clr_exc();
        chk("mret_req", 64'(bus.trap_req_o), 64'd1);
        chk("mret_addr", bus.trap_addr_o, 64'h8000_0040);
        chk_wr("mret_mstatus", 12'h300, 64'h1888);
        chk("mret_hold", 64'(bus.hold_o), 64'd1);
        tick();
        chk("mret_hold_end", 64'(bus.hold_o), 64'd0);
        chk("mret_we_end", 64'(bus.csr_we_o), 64'd0);

        // MIE clear: a pending timer interrupt is not taken
        bus.csr_mstatus_i = 64'h0; bus.csr_mie_i = 64'h80; bus.tmr_irq_i = 1'b1;
        tick();
        chk("mie0_req", 64'(bus.trap_req_o), 64'd0);
        chk("mie0_we", 64'(bus.csr_we_o), 64'd0);
        tick();
        chk("mie0_hold", 64'(bus.hold_o), 64'd0);

        // MTI with mtvec mode 01
        bus.csr_mstatus_i = 64'h8; bus.csr_mtvec_i = 64'h8000_0101;
        tick();
        bus.tmr_irq_i = 1'b0;
        chk("mti_req", 64'(bus.trap_req_o), 64'd1);
`ifdef TRAP_VECTORED_EN
        chk("mti_vec_addr", bus.trap_addr_o, 64'h8000_011C);
`else
        chk("mti_vec_addr", bus.trap_addr_o, 64'h8000_0100);
`endif
        tick();
        chk_wr("mti_mcause", 12'h342, 64'h8000_0000_0000_0007);
        repeat (3) tick();
        chk("mti_idle", 64'(bus.hold_o), 64'd0);

        // Sync exception together with MRET: the trap path wins
        bus.csr_mtvec_i = 64'h8000_0100;
        bus.exc_vld_if = 1'b1; bus.exc_cause_if = 4'd3; bus.exc_pc_if = 64'h3000;
        bus.mret_i = 1'b1;
        tick();
        clr_exc();
        chk("both_addr", bus.trap_addr_o, 64'h8000_0100);
        chk_wr("both_mepc", 12'h341, 64'h3000);
        repeat (4) tick();
        chk("both_idle", 64'(bus.hold_o), 64'd0);

        // Reset in MCAUSE aborts the remaining writes
        bus.exc_vld_ex = 1'b1; bus.exc_cause_ex = 4'd4; bus.exc_pc_ex = 64'h4000;
        tick();
        clr_exc();
        tick();
        chk_wr("arst_mcause", 12'h342, 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", 64'(bus.csr_we_o), 64'd0);
        chk("arst_hold", 64'(bus.hold_o), 64'd0);
        chk("arst_data", bus.csr_data_o, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_post_we", 64'(bus.csr_we_o), 64'd0);
            chk("arst_post_hold", 64'(bus.hold_o), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
